// File: rtl/msp430_dbg_hwbrk_cnt.sv
// msp430_dbg_hwbrk_cnt: breakpoint/watchpoint unit with address/range matching, data qualification and pass counter
module msp430_dbg_hwbrk_cnt #(
  parameter int AW = 16,
  parameter int CNT_W = 8,
  parameter bit RANGE_EN = 1'b1,
  parameter bit DATA_EN = 1'b1
) (
  input  logic          dbg_clk,
  input  logic          dbg_rst,
  input  logic [5:0]    brk_reg_rd,
  input  logic [5:0]    brk_reg_wr,
  input  logic [15:0]   dbg_din,
  input  logic          decode_noirq,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] eu_mab,
  input  logic          eu_mb_en,
  input  logic [1:0]    eu_mb_wr,
  input  logic [15:0]   eu_mdb_out,
  output logic          brk_halt,
  output logic          brk_pnd,
  output logic [15:0]   brk_dout
);
  typedef enum logic [1:0] {DISARMED, ARMED, FIRED} state_t;
  localparam logic [7:0] CTL_MASK = {2'b11, DATA_EN, RANGE_EN, 4'hf};
  state_t state_q, state_d;
  logic [7:0] ctl_q, ctl_d;
  logic [5:0] stat_q, stat_d;
  logic [AW-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [15:0] data_q, data_d;
  logic [CNT_W-1:0] reload_q, reload_d, rem_q, rem_d;
  logic [AW-1:0] a;
  logic acc_v, acc_wr, dq, rd_ok, wr_ok, hit0, hit1, in_rng, qual;
  logic [5:0] flags, set;
  always_comb begin
    a = ctl_q[3] ? pc : eu_mab;
    acc_v = ctl_q[3] ? decode_noirq : eu_mb_en;
    acc_wr = ~ctl_q[3] & (|eu_mb_wr);
    // Only byte lanes actually being written take part in the data compare
    dq = ~ctl_q[5] | ((~eu_mb_wr[0] | (eu_mdb_out[7:0] == data_q[7:0])) &
                      (~eu_mb_wr[1] | (eu_mdb_out[15:8] == data_q[15:8])));
    rd_ok = (state_q == ARMED) & ctl_q[0] & acc_v & ~acc_wr;
    wr_ok = (state_q == ARMED) & ctl_q[1] & acc_v & acc_wr & dq;
    hit0 = ~ctl_q[4] & (a == addr0_q);
    hit1 = ~ctl_q[4] & (a == addr1_q);
    in_rng = ctl_q[4] & (a >= addr0_q) & (a <= addr1_q);
    flags = {in_rng & wr_ok, in_rng & rd_ok, hit1 & wr_ok, hit1 & rd_ok, hit0 & wr_ok, hit0 & rd_ok};
    qual = (|flags) & (~ctl_q[6] | (rem_q == '0)) & ~brk_reg_wr[0];
    set = qual ? flags : '0;
    brk_halt = qual & ctl_q[2];
    brk_pnd = |stat_q;
    ctl_d = brk_reg_wr[0] ? dbg_din[7:0] & CTL_MASK : ctl_q;
    stat_d = (stat_q & ~(brk_reg_wr[1] ? dbg_din[5:0] : 6'h0)) | set;
    addr0_d = brk_reg_wr[2] ? dbg_din[AW-1:0] : addr0_q;
    addr1_d = brk_reg_wr[3] ? dbg_din[AW-1:0] : addr1_q;
    data_d = brk_reg_wr[4] ? dbg_din & {16{DATA_EN}} : data_q;
    reload_d = brk_reg_wr[5] ? dbg_din[CNT_W-1:0] : reload_q;
    state_d = brk_reg_wr[0] ? ((dbg_din[1:0] != 2'b00) ? ARMED : DISARMED) :
              qual ? (ctl_q[7] ? FIRED : ARMED) : state_q;
    // A CNT write beats both the arm reload and the event-driven update
    rem_d = brk_reg_wr[5] ? dbg_din[CNT_W-1:0] :
            (brk_reg_wr[0] | qual) ? reload_q :
            (|flags) ? rem_q - CNT_W'(1) : rem_q;
    brk_dout = (brk_reg_rd[0] ? 16'(ctl_q) : 16'h0) |
               (brk_reg_rd[1] ? 16'({state_q == ARMED, state_q == FIRED, stat_q}) : 16'h0) |
               (brk_reg_rd[2] ? 16'(addr0_q) : 16'h0) |
               (brk_reg_rd[3] ? 16'(addr1_q) : 16'h0) |
               (brk_reg_rd[4] ? data_q : 16'h0) |
               (brk_reg_rd[5] ? 16'(rem_q) : 16'h0);
  end
  always_ff @(posedge dbg_clk) begin
    if (dbg_rst) begin
      state_q <= DISARMED;
      ctl_q <= '0;
      stat_q <= '0;
      addr0_q <= '0;
      addr1_q <= '0;
      data_q <= '0;
      reload_q <= '0;
      rem_q <= '0;
    end else begin
      state_q <= state_d;
      ctl_q <= ctl_d;
      stat_q <= stat_d;
      addr0_q <= addr0_d;
      addr1_q <= addr1_d;
      data_q <= data_d;
      reload_q <= reload_d;
      rem_q <= rem_d;
    end
  end
endmodule

// File: tb/tb_msp430_dbg_hwbrk_cnt.sv
// tb_msp430_dbg_hwbrk_cnt: directed and random checks of the breakpoint unit against a behavioural model
module tb_msp430_dbg_hwbrk_cnt;
  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] brk_reg_rd = '0, brk_reg_wr = '0;
  logic [15:0] dbg_din = '0, pc = '0, eu_mab = '0, eu_mdb_out = '0;
  logic decode_noirq = 1'b0, eu_mb_en = 1'b0;
  logic [1:0] eu_mb_wr = '0;
  logic brk_halt, brk_pnd, halt1, pnd1;
  logic [15:0] brk_dout, dout1;
  int ncmp = 0, nfail = 0;
  logic [15:0] m_ctl = '0, m_stat = '0, m_a0 = '0, m_a1 = '0, m_data = '0, m_rel = '0, m_rem = '0;
  int m_st = 0;
  logic s_halt, s_pnd;
  logic [15:0] s_dout, s_dout1;

  always #5 clk = ~clk;

  msp430_dbg_hwbrk_cnt dut (
    .dbg_clk(clk), .dbg_rst(rst), .brk_reg_rd(brk_reg_rd), .brk_reg_wr(brk_reg_wr),
    .dbg_din(dbg_din), .decode_noirq(decode_noirq), .pc(pc), .eu_mab(eu_mab),
    .eu_mb_en(eu_mb_en), .eu_mb_wr(eu_mb_wr), .eu_mdb_out(eu_mdb_out),
    .brk_halt(brk_halt), .brk_pnd(brk_pnd), .brk_dout(brk_dout)
  );

  msp430_dbg_hwbrk_cnt #(.RANGE_EN(1'b0), .DATA_EN(1'b0)) u1 (
    .dbg_clk(clk), .dbg_rst(rst), .brk_reg_rd(brk_reg_rd), .brk_reg_wr(brk_reg_wr),
    .dbg_din(dbg_din), .decode_noirq(decode_noirq), .pc(pc), .eu_mab(eu_mab),
    .eu_mb_en(eu_mb_en), .eu_mb_wr(eu_mb_wr), .eu_mdb_out(eu_mdb_out),
    .brk_halt(halt1), .brk_pnd(pnd1), .brk_dout(dout1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: predict outputs from the model, sample at negedge, then advance the model at posedge
  task automatic tick();
    logic [15:0] a, lane, e_dout;
    logic [15:0] rv [6];
    logic [5:0] f, sn;
    bit v, w, q, e_halt;
    int k;
    if (m_ctl[3]) begin a = pc; v = decode_noirq; w = 1'b0; end
    else begin a = eu_mab; v = eu_mb_en; w = (eu_mb_wr != 2'b00); end
    lane = {{8{eu_mb_wr[1]}}, {8{eu_mb_wr[0]}}};
    k = w ? 1 : 0;
    f = '0;
    if (m_st == 1 && v && m_ctl[k] && !(w && m_ctl[5] && ((eu_mdb_out ^ m_data) & lane) != 16'h0)) begin
      if (m_ctl[4]) f[4+k] = (a >= m_a0 && a <= m_a1);
      else begin
        f[k] = (a == m_a0);
        f[2+k] = (a == m_a1);
      end
    end
    q = (f != 6'h0) && (!m_ctl[6] || m_rem == 16'h0) && !brk_reg_wr[0];
    e_halt = q && m_ctl[2];
    rv[0] = m_ctl;
    rv[1] = m_stat | (m_st == 1 ? 16'h80 : 16'h0) | (m_st == 2 ? 16'h40 : 16'h0);
    rv[2] = m_a0; rv[3] = m_a1; rv[4] = m_data; rv[5] = m_rem;
    e_dout = '0;
    for (int i = 0; i < 6; i++) if (brk_reg_rd[i]) e_dout |= rv[i];
    @(negedge clk);
    s_halt = brk_halt; s_pnd = brk_pnd; s_dout = brk_dout; s_dout1 = dout1;
    chk("halt", 16'(brk_halt), 16'(e_halt));
    chk("pnd", 16'(brk_pnd), 16'(m_stat != 16'h0));
    chk("dout", brk_dout, e_dout);
    @(posedge clk);
    sn = m_stat[5:0] & ~(brk_reg_wr[1] ? dbg_din[5:0] : 6'h0);
    if (q) sn |= f;
    m_stat = 16'(sn);
    if (brk_reg_wr[0]) begin
      m_ctl = dbg_din & 16'h00FF;
      m_st = (dbg_din[1:0] != 2'b00) ? 1 : 0;
      m_rem = m_rel;
    end else if (q) begin
      m_rem = m_rel;
      m_st = m_ctl[7] ? 2 : 1;
    end else if (f != 6'h0) m_rem = m_rem - 16'h1;
    if (brk_reg_wr[2]) m_a0 = dbg_din;
    if (brk_reg_wr[3]) m_a1 = dbg_din;
    if (brk_reg_wr[4]) m_data = dbg_din;
    if (brk_reg_wr[5]) begin m_rel = dbg_din & 16'h00FF; m_rem = m_rel; end
    #1;
  endtask

  task automatic rd(input int i);
    brk_reg_rd = 6'(1 << i);
    tick();
    brk_reg_rd = '0;
  endtask

  task automatic wr(input int i, input logic [15:0] val);
    brk_reg_wr = 6'(1 << i);
    dbg_din = val;
    tick();
    brk_reg_wr = '0;
    dbg_din = '0;
  endtask

  task automatic ev_d(input logic [15:0] addr, input logic [1:0] we, input logic [15:0] d);
    eu_mb_en = 1'b1; eu_mab = addr; eu_mb_wr = we; eu_mdb_out = d;
    tick();
    eu_mb_en = 1'b0; eu_mab = '0; eu_mb_wr = '0; eu_mdb_out = '0;
  endtask

  task automatic ev_i(input logic [15:0] addr);
    decode_noirq = 1'b1; pc = addr;
    tick();
    decode_noirq = 1'b0; pc = '0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rd(i);
      chk("reset_reg", s_dout, 16'h0);
    end
    chk("reset_pnd", 16'(s_pnd), 16'h0);
    chk("reset_halt", 16'(s_halt), 16'h0);
    chk("reset_u1", 16'({halt1, pnd1}), 16'h0);

    wr(2, 16'h1234);
    wr(0, 16'h0006);
    ev_d(16'h1234, 2'b11, 16'h5555);
    chk("addr_wr_halt", 16'(s_halt), 16'h1);
    rd(1);
    chk("addr_wr_stat", s_dout, 16'h0082);
    wr(1, 16'h0002);
    rd(1);
    chk("w1c_stat", s_dout, 16'h0080);
    chk("w1c_pnd", 16'(s_pnd), 16'h0);

    wr(4, 16'hAB00);
    wr(0, 16'h0026);
    ev_d(16'h1234, 2'b10, 16'hABFF);
    chk("dm_hi_hit", 16'(s_halt), 16'h1);
    ev_d(16'h1234, 2'b10, 16'hAC00);
    chk("dm_hi_miss", 16'(s_halt), 16'h0);
    ev_d(16'h1234, 2'b01, 16'h0000);
    chk("dm_lo_hit", 16'(s_halt), 16'h1);
    rd(4);
    chk("data_rd", s_dout, 16'hAB00);
    chk("u1_data_rd", s_dout1, 16'h0);

    wr(1, 16'h003F);
    wr(2, 16'h0040);
    wr(5, 16'h0003);
    wr(0, 16'h00CD);
    for (int i = 0; i < 5; i++) begin
      rd(5);
      chk("cnt_rem", s_dout, (i < 4) ? 16'(3 - i) : 16'h3);
      ev_i(16'h0040);
      chk("cnt_halt", 16'(s_halt), (i == 3) ? 16'h1 : 16'h0);
    end
    rd(1);
    chk("cnt_fired", s_dout, 16'h0041);

    wr(2, 16'h0200);
    wr(3, 16'h0100);
    wr(0, 16'h0011);
    rd(0);
    chk("ctl_range", s_dout, 16'h0011);
    chk("u1_ctl_mask", s_dout1, 16'h0001);
    wr(1, 16'h003F);
    ev_d(16'h0180, 2'b00, 16'h0);
    rd(1);
    chk("rng_empty", s_dout, 16'h0080);
    wr(2, 16'h0100);
    wr(3, 16'h0200);
    ev_d(16'h0100, 2'b00, 16'h0);
    rd(1);
    chk("rng_lo", s_dout, 16'h0090);
    chk("u1_no_rng", s_dout1 & 16'h0030, 16'h0);
    wr(1, 16'h003F);
    ev_d(16'h0200, 2'b00, 16'h0);
    rd(1);
    chk("rng_hi", s_dout, 16'h0090);
    wr(1, 16'h003F);
    ev_d(16'h0201, 2'b00, 16'h0);
    rd(1);
    chk("rng_out", s_dout, 16'h0080);

    wr(2, 16'h0300);
    wr(0, 16'h0001);
    wr(1, 16'h003F);
    eu_mb_en = 1'b1; eu_mab = 16'h0300; brk_reg_wr = 6'b000010; dbg_din = 16'h0001;
    tick();
    eu_mb_en = 1'b0; eu_mab = '0; brk_reg_wr = '0; dbg_din = '0;
    rd(1);
    chk("set_wins", s_dout, 16'h0081);
    wr(1, 16'h003F);
    wr(5, 16'h0002);
    wr(0, 16'h0041);
    ev_d(16'h0300, 2'b00, 16'h0);
    rd(5);
    chk("pre_ctl_rem", s_dout, 16'h0001);
    eu_mb_en = 1'b1; eu_mab = 16'h0300; brk_reg_wr = 6'b000001; dbg_din = 16'h0041;
    tick();
    eu_mb_en = 1'b0; eu_mab = '0; brk_reg_wr = '0; dbg_din = '0;
    rd(1);
    chk("ctl_wins_stat", s_dout, 16'h0080);
    rd(5);
    chk("ctl_wins_rem", s_dout, 16'h0002);

    for (int n = 0; n < 400; n++) begin
      brk_reg_rd = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(1 << $urandom_range(0, 5));
      brk_reg_wr = ($urandom_range(0, 7) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'h0;
      dbg_din = 16'($urandom);
      if (brk_reg_wr[2] | brk_reg_wr[3]) dbg_din &= 16'h000F;
      if (brk_reg_wr[4]) dbg_din &= 16'h0101;
      if (brk_reg_wr[5]) dbg_din &= 16'h0003;
      pc = 16'($urandom_range(0, 15));
      eu_mab = 16'($urandom_range(0, 15));
      decode_noirq = 1'($urandom);
      eu_mb_en = 1'($urandom);
      eu_mb_wr = 2'($urandom);
      eu_mdb_out = 16'($urandom) & 16'h0101;
      tick();
    end
    brk_reg_rd = '0; brk_reg_wr = '0; dbg_din = '0; decode_noirq = 1'b0; eu_mb_en = 1'b0; eu_mb_wr = '0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
